// File: rtl/spi_master_slave.sv
// SPI master and SPI slave wired back-to-back on sclk/mosi/miso inside one clock domain.
// The master generates sclk from clk; the slave re-synchronises the SPI wires and detects edges.
module spi_master_slave #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       tx_ready,
  output logic       done,
  input  logic       cs,
  input  logic [7:0] so_data,
  input  logic       so_start,
  output logic       so_ready,
  output logic [7:0] si_data,
  output logic       si_done,
  output logic       sclk,
  output logic       mosi,
  output logic       miso
);

  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } m_state_t;

  // ---------------------------------------------------------------------------
  // Master
  // ---------------------------------------------------------------------------
  m_state_t   m_state;
  logic [7:0] m_tx_shift;
  logic [7:0] m_rx_shift;
  logic [2:0] m_bit_cnt;
  logic       m_phase;      // 0 = H0, 1 = H1
  logic [7:0] hp_cnt;
  logic       cpol_l;
  logic       cpha_l;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge values of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_state    <= IDLE;
      tx_ready   <= 1'b1;
      done       <= 1'b0;
      rx_data    <= 8'h00;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      m_tx_shift <= 8'h00;
      m_rx_shift <= 8'h00;
      m_bit_cnt  <= 3'd0;
      m_phase    <= 1'b0;
      hp_cnt     <= 8'd0;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (m_state)
        IDLE: begin
          tx_ready <= 1'b1;
          sclk     <= cpol;
          if (start) begin
            m_tx_shift <= tx_data;
            cpol_l     <= cpol;
            cpha_l     <= cpha;
            m_bit_cnt  <= 3'd0;
            m_phase    <= 1'b0;
            hp_cnt     <= 8'd0;
            mosi       <= tx_data[7];
            // H0 level: cpol for CPHA=0, ~cpol for CPHA=1 (leading edge right away)
            sclk       <= cpol ^ cpha;
            tx_ready   <= 1'b0;
            m_state    <= XFER;
          end
        end
        XFER: begin
          if (hp_cnt == HP_LAST) begin
            hp_cnt <= 8'd0;
            if (!m_phase) begin
              m_phase    <= 1'b1;
              sclk       <= ~(cpol_l ^ cpha_l);
              m_rx_shift <= {m_rx_shift[6:0], miso};
            end else if (m_bit_cnt == 3'd7) begin
              m_state <= DONE;
              sclk    <= cpol_l;
              done    <= 1'b1;
              rx_data <= m_rx_shift;
            end else begin
              m_phase    <= 1'b0;
              m_bit_cnt  <= m_bit_cnt + 3'd1;
              sclk       <= cpol_l ^ cpha_l;
              mosi       <= m_tx_shift[6];
              m_tx_shift <= {m_tx_shift[6:0], 1'b0};
            end
          end else begin
            hp_cnt <= hp_cnt + 8'd1;
          end
        end
        DONE: begin
          m_state  <= IDLE;
          tx_ready <= 1'b1;
          sclk     <= cpol_l;
        end
        default: m_state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Slave
  // ---------------------------------------------------------------------------
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       mosi_s1, mosi_s2;
  logic       cs_s1, cs_s2;
  logic [7:0] s_tx_shift;
  logic [7:0] s_rx_shift;
  logic [2:0] s_bit_cnt;
  logic       lead_edge, trail_edge, sample_edge, shift_edge;

  // cs sync resets to deselected so miso idles high straight out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
    end
  end

  assign lead_edge   = (sclk_s2 != sclk_s3) && (sclk_s2 != cpol);
  assign trail_edge  = (sclk_s2 != sclk_s3) && (sclk_s2 == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign miso        = cs_s2 ? 1'b1 : s_tx_shift[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      s_tx_shift <= 8'h00;
      s_rx_shift <= 8'h00;
      s_bit_cnt  <= 3'd0;
      si_data    <= 8'h00;
      si_done    <= 1'b0;
      so_ready   <= 1'b1;
    end else begin
      si_done <= 1'b0;
      if (cs_s2) begin
        s_bit_cnt  <= 3'd0;
        s_rx_shift <= 8'h00;
        so_ready   <= 1'b1;
        if (so_start) s_tx_shift <= so_data;
      end else begin
        // In CPHA=1 the first leading edge only presents bit 7, it must not shift it away
        if (shift_edge && !(cpha && (s_bit_cnt == 3'd0)))
          s_tx_shift <= {s_tx_shift[6:0], 1'b0};
        if (sample_edge) begin
          s_rx_shift <= {s_rx_shift[6:0], mosi_s2};
          s_bit_cnt  <= s_bit_cnt + 3'd1;
          if (s_bit_cnt == 3'd7) begin
            si_data    <= {s_rx_shift[6:0], mosi_s2};
            si_done    <= 1'b1;
            so_ready   <= 1'b1;
            s_tx_shift <= 8'h00;  // an unloaded next byte goes out as 0x00
          end
        end
        if (so_start && so_ready) begin
          s_tx_shift <= so_data;
          so_ready   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_slave.sv
// Directed bench for spi_master_slave: byte exchange in all four modes, cs abort,
// unloaded slave, protocol misuse and mid-transfer reset.
module tb_spi_master_slave;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       reset, start, cpol, cpha, cs, so_start;
  logic [7:0] tx_data, so_data;
  logic [7:0] rx_data, si_data;
  logic       tx_ready, done, so_ready, si_done, sclk, mosi, miso;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0, si_cnt = 0, lead_cnt = 0;
  logic sclk_prev = 1'b0;

  spi_master_slave #(.HALF_PERIOD(HP)) dut (
    .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .rx_data(rx_data), .tx_ready(tx_ready), .done(done),
    .cs(cs), .so_data(so_data), .so_start(so_start), .so_ready(so_ready),
    .si_data(si_data), .si_done(si_done), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // Pulse and leading-edge counters, sampled mid-cycle
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (si_done) si_cnt++;
    if (sclk_prev == cpol && sclk != cpol) lead_cnt++;
    sclk_prev = sclk;
  end

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    cpol = pol;
    cpha = pha;
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // load_mode: 0 = no slave load, 1 = load a few clocks early, 2 = load with start
  task automatic run_xfer(input string tag, input logic [7:0] mtx, input logic [7:0] sby,
                          input int load_mode, input bit misuse, input logic [7:0] exp_rx,
                          input logic [7:0] exp_si, input int exp_si_cnt);
    done_cnt = 0; si_cnt = 0; lead_cnt = 0;
    if (load_mode == 1) begin
      so_data = sby; so_start = 1'b1;
      @(negedge clk);
      so_start = 1'b0; so_data = 8'h00;
      repeat (4) @(negedge clk);
      check({tag, " so_ready loaded"}, {7'd0, so_ready}, 8'd0);
    end
    check({tag, " sclk idle before"}, {7'd0, sclk}, {7'd0, cpol});
    tx_data = mtx; start = 1'b1;
    if (load_mode == 2) begin so_data = sby; so_start = 1'b1; end
    @(negedge clk);
    start = 1'b0; tx_data = 8'h00; so_start = 1'b0; so_data = 8'h00;
    check({tag, " tx_ready T+1"}, {7'd0, tx_ready}, 8'd0);
    if (load_mode == 2) check({tag, " so_ready T+1"}, {7'd0, so_ready}, 8'd0);
    for (int i = 1; i < 16 * HP; i++) begin
      @(negedge clk);
      if (misuse && i == 10) begin
        start = 1'b1; tx_data = 8'h00; so_start = 1'b1; so_data = 8'hFF;
      end else begin
        start = 1'b0; so_start = 1'b0;
      end
    end
    check({tag, " done not early"}, {7'd0, done}, 8'd0);
    @(negedge clk);
    check({tag, " done at T+1+16HP"}, {7'd0, done}, 8'd1);
    check({tag, " rx_data"}, rx_data, exp_rx);
    @(negedge clk);
    check({tag, " done one cycle"}, {7'd0, done}, 8'd0);
    check({tag, " tx_ready back"}, {7'd0, tx_ready}, 8'd1);
    repeat (2) @(negedge clk);
    check({tag, " sclk idle after"}, {7'd0, sclk}, {7'd0, cpol});
    check({tag, " done count"}, 8'(done_cnt), 8'd1);
    check({tag, " leading edges"}, 8'(lead_cnt), 8'd8);
    check({tag, " si_done count"}, 8'(si_cnt), 8'(exp_si_cnt));
    check({tag, " si_data"}, si_data, exp_si);
    check({tag, " so_ready after"}, {7'd0, so_ready}, 8'd1);
    check({tag, " rx_data held"}, rx_data, exp_rx);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " tx_ready"}, {7'd0, tx_ready}, 8'd1);
    check({tag, " done"}, {7'd0, done}, 8'd0);
    check({tag, " rx_data"}, rx_data, 8'h00);
    check({tag, " sclk"}, {7'd0, sclk}, 8'd0);
    check({tag, " mosi"}, {7'd0, mosi}, 8'd0);
    check({tag, " si_data"}, si_data, 8'h00);
    check({tag, " si_done"}, {7'd0, si_done}, 8'd0);
    check({tag, " so_ready"}, {7'd0, so_ready}, 8'd1);
    check({tag, " miso"}, {7'd0, miso}, 8'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; cpol = 1'b0; cpha = 1'b0; cs = 1'b0;
    so_start = 1'b0; tx_data = 8'hA5; so_data = 8'h00;
    // start held alongside reset must be ignored
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    start = 1'b0; reset = 1'b0;
    repeat (4) @(negedge clk);

    // Mode 0, slave load concurrent with master start
    run_xfer("mode0", 8'hF0, 8'hAA, 2, 1'b0, 8'hAA, 8'hF0, 1);

    set_mode(1'b0, 1'b1);
    run_xfer("mode1", 8'h0F, 8'h55, 1, 1'b0, 8'h55, 8'h0F, 1);
    set_mode(1'b1, 1'b0);
    run_xfer("mode2", 8'hAA, 8'h33, 1, 1'b0, 8'h33, 8'hAA, 1);
    set_mode(1'b1, 1'b1);
    run_xfer("mode3", 8'h55, 8'hC3, 1, 1'b0, 8'hC3, 8'h55, 1);

    // Slave deselected for the whole transfer: miso stays high, no slave byte
    set_mode(1'b0, 1'b0);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    run_xfer("cs_high", 8'h5A, 8'h00, 0, 1'b0, 8'hFF, 8'h55, 0);
    cs = 1'b0;
    repeat (4) @(negedge clk);

    // Nothing loaded into the slave: it returns 0x00
    run_xfer("no_load", 8'h81, 8'h00, 0, 1'b0, 8'h00, 8'h81, 1);

    // Extra start and so_start mid-transfer are both ignored
    run_xfer("misuse", 8'h5A, 8'hA5, 1, 1'b1, 8'hA5, 8'h5A, 1);

    // Reset in the middle of bit 4
    so_data = 8'h34; so_start = 1'b1;
    @(negedge clk);
    so_start = 1'b0;
    repeat (4) @(negedge clk);
    tx_data = 8'h12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8 * 4 + 2) @(negedge clk);
    check("pre-reset busy", {7'd0, tx_ready}, 8'd0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("mid reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    run_xfer("after_reset", 8'h3C, 8'hC3, 1, 1'b0, 8'hC3, 8'h3C, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
